game_timer_ctrl: RTL and testbench
==================================

# game_timer_ctrl

Timed-mode scheduler for the snake game. Sits between Snake_control and Master_state_machine. Runs a 1 Hz countdown from a prescaled CLK and counts TARGET_REACHED pulses against a goal. It reports time-up or goal-met so the master state machine can end the round. In untimed mode it only keeps score.

## Interface
- CLK_HZ, 100000000: CLK frequency; the prescaler terminal count is CLK_HZ-1.
- GAME_SECONDS, 60: countdown start value, 1..99.
- TARGET_GOAL, 10: targets needed to win, 1..15.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- TIMED_MODE  in  1  SW15 level; sampled only in IDLE.
- MSM_STATE  in  2  master state: 2'b00 start screen, 2'b01 play, 2'b10 win, 2'b11 lost.
- TARGET_REACHED  in  1  one-cycle pulse from Snake_control.
- TICK_1HZ  out  1  one-cycle pulse on each countdown step.
- SECONDS_LEFT  out  8  remaining seconds; encoding depends on the macro in Configuration.
- SCORE  out  4  targets eaten this round, binary, saturates at TARGET_GOAL.
- TIME_UP  out  1  level; countdown reached 0 before the goal was met.
- GOAL_MET  out  1  level; SCORE reached TARGET_GOAL in timed mode.
- TIMED_ACTIVE  out  1  level; the round in progress is timed.

## Operation
- States: IDLE, RUNNING, EXPIRED, WON.
- IDLE:
  - Prescaler = 0, SECONDS_LEFT = GAME_SECONDS, SCORE = 0, TIME_UP = GOAL_MET = 0.
  - TIMED_ACTIVE tracks TIMED_MODE each cycle.
  - Goes to RUNNING when MSM_STATE == 2'b01.
- RUNNING:
  - Each TARGET_REACHED pulse increments SCORE, saturating at TARGET_GOAL.
  - Timed round: prescaler counts 0..CLK_HZ-1. At the terminal count it wraps to 0, TICK_1HZ pulses and SECONDS_LEFT decrements.
  - Timed round, decrement from 1 to 0 → EXPIRED, TIME_UP = 1.
  - Timed round, SCORE becomes TARGET_GOAL → WON, GOAL_MET = 1.
  - Untimed round: prescaler is held at 0, there are no ticks, SECONDS_LEFT is frozen, and the FSM never leaves RUNNING except by the exit rule.
- EXPIRED / WON:
  - Counters and outputs frozen; further TARGET_REACHED pulses are ignored.
- Exit rule, any non-IDLE state: when MSM_STATE == 2'b00, go to IDLE on the next edge and clear everything.
- TIMED_MODE changes outside IDLE are ignored; TIMED_ACTIVE holds the value latched on IDLE exit.
- Simultaneous goal-completing TARGET_REACHED and final tick (1→0) on the same cycle: goal wins. Result is WON, GOAL_MET = 1, TIME_UP = 0, SECONDS_LEFT = 0.
- MSM_STATE at 2'b10 or 2'b11 while RUNNING (master ended the round for its own reason, e.g. collision): freeze counters and stay in RUNNING until 2'b00.

## Timing
- All outputs are registered.
- Reset values: TICK_1HZ = 0, SECONDS_LEFT = GAME_SECONDS (encoded), SCORE = 0, TIME_UP = 0, GOAL_MET = 0, TIMED_ACTIVE = 0. FSM = IDLE.
- Reset wins over every other input on the same edge, including mid-round.
- TARGET_REACHED high in cycle N: SCORE updates at edge N+1. GOAL_MET and the WON transition happen at that same edge.
- First TICK_1HZ comes CLK_HZ cycles after the IDLE→RUNNING edge. Later ticks are every CLK_HZ cycles.
- SECONDS_LEFT and TIME_UP update on the same edge as the TICK_1HZ assertion.
- IDLE→RUNNING happens on the first edge where MSM_STATE == 2'b01 is sampled; that one-cycle latency is the only latency.

## Configuration
- GAME_TIMER_BCD_EN defined:
  - SECONDS_LEFT is two packed BCD digits (60 → 8'h60).
  - Decrement borrows from the tens digit when units = 0 (units → 9), e.g. 8'h50 → 8'h49.
  - Ready for the seven-segment driver.
- Not defined:
  - SECONDS_LEFT is plain binary, zero-extended (60 → 8'h3C).
  - No BCD logic is synthesised.

## Test plan
- Reset mid-round: RESET low one cycle while RUNNING with SCORE = 3 → next cycle SCORE = 0, SECONDS_LEFT = GAME_SECONDS, FSM IDLE, all flags 0.
- Timed expiry (CLK_HZ = 4, GAME_SECONDS = 3, TIMED_MODE = 1, MSM_STATE → 01, no targets) → TICK_1HZ pulses 4, 8 and 12 cycles after entry. SECONDS_LEFT goes 3, 2, 1, 0; TIME_UP = 1 at cycle 12 and holds.
- Goal met (TARGET_GOAL = 10, ten TARGET_REACHED pulses before timeout) → SCORE = 10, GOAL_MET = 1 one cycle after the tenth pulse, countdown frozen. An eleventh pulse leaves SCORE = 10.
- Simultaneous final tick and tenth target → GOAL_MET = 1, TIME_UP = 0, SECONDS_LEFT = 0.
- Untimed round (TIMED_MODE = 0): 5 targets over 50 ticks' worth of cycles → SCORE = 5, no TICK_1HZ, SECONDS_LEFT unchanged. Toggling TIMED_MODE mid-round has no effect.
- BCD build (GAME_TIMER_BCD_EN, GAME_SECONDS = 60) → SECONDS_LEFT sequence 8'h60, 8'h59, …, 8'h50, 8'h49. Binary build: 8'h3C, 8'h3B.

Source files
------------

// File: rtl/game_timer_ctrl_if.sv
// game_timer_ctrl_if: bus between the master state machine side and the
// timed-mode scheduler. The master modport drives mode/state/target pulses
// and observes the timer results; the slave modport is the scheduler itself.
interface game_timer_ctrl_if;
    logic       TIMED_MODE;
    logic [1:0] MSM_STATE;
    logic       TARGET_REACHED;
    logic       TICK_1HZ;
    logic [7:0] SECONDS_LEFT;
    logic [3:0] SCORE;
    logic       TIME_UP;
    logic       GOAL_MET;
    logic       TIMED_ACTIVE;

    modport master (
        output TIMED_MODE,
        output MSM_STATE,
        output TARGET_REACHED,
        input  TICK_1HZ,
        input  SECONDS_LEFT,
        input  SCORE,
        input  TIME_UP,
        input  GOAL_MET,
        input  TIMED_ACTIVE
    );

    modport slave (
        input  TIMED_MODE,
        input  MSM_STATE,
        input  TARGET_REACHED,
        output TICK_1HZ,
        output SECONDS_LEFT,
        output SCORE,
        output TIME_UP,
        output GOAL_MET,
        output TIMED_ACTIVE
    );
endinterface

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: timed-mode scheduler for the snake game.
// Runs a 1 Hz countdown derived from CLK through a CLK_HZ prescaler and
// counts TARGET_REACHED pulses against TARGET_GOAL, reporting TIME_UP or
// GOAL_MET. Untimed rounds only keep score.
// Optional macro GAME_TIMER_BCD_EN: SECONDS_LEFT is packed two-digit BCD
// instead of zero-extended binary.
module game_timer_ctrl #(
    parameter int CLK_HZ       = 100000000,
    parameter int GAME_SECONDS = 60,
    parameter int TARGET_GOAL  = 10
) (
    input logic              CLK,
    input logic              RESET,
    game_timer_ctrl_if.slave bus
);

    localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [3:0]       GOAL     = 4'(TARGET_GOAL);
`ifdef GAME_TIMER_BCD_EN
    localparam logic [7:0] SECONDS_INIT = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
`else
    localparam logic [7:0] SECONDS_INIT = 8'(GAME_SECONDS);
`endif

    localparam logic [1:0] MSM_START = 2'b00;
    localparam logic [1:0] MSM_PLAY  = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2,
        WON     = 2'd3
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] prescaler;
    logic [7:0]       seconds_left;
    logic [3:0]       score;
    logic             tick;
    logic             time_up;
    logic             goal_met;
    logic             timed_active;

    logic             prescaler_wrap;
    logic             target_counted;
    logic             goal_hit;
    logic [7:0]       seconds_dec;

    // One-second decrement in whichever encoding SECONDS_LEFT uses; BCD
    // borrows from the tens digit when the units digit is already zero.
    always_comb begin
`ifdef GAME_TIMER_BCD_EN
        seconds_dec = seconds_left;
        if (seconds_left[3:0] == 4'd0) begin
            seconds_dec = {seconds_left[7:4] - 4'd1, 4'd9};
        end else begin
            seconds_dec = {seconds_left[7:4], seconds_left[3:0] - 4'd1};
        end
`else
        seconds_dec = seconds_left - 8'd1;
`endif
    end

    // Score only moves below the goal, so saturation falls out naturally and
    // the goal is hit exactly when the counted target lifts score to GOAL.
    assign prescaler_wrap = (prescaler == PRE_LAST);
    assign target_counted = bus.TARGET_REACHED && (score != GOAL);
    assign goal_hit       = target_counted && (score == GOAL - 4'd1);

    // Round FSM with registered counters and flags; goal beats the final
    // tick when both land on the same edge.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= IDLE;
            prescaler    <= '0;
            seconds_left <= SECONDS_INIT;
            score        <= 4'd0;
            tick         <= 1'b0;
            time_up      <= 1'b0;
            goal_met     <= 1'b0;
            timed_active <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                IDLE: begin
                    prescaler    <= '0;
                    seconds_left <= SECONDS_INIT;
                    score        <= 4'd0;
                    time_up      <= 1'b0;
                    goal_met     <= 1'b0;
                    timed_active <= bus.TIMED_MODE;
                    if (bus.MSM_STATE == MSM_PLAY) begin
                        state <= RUNNING;
                    end
                end
                default: begin
                    if (bus.MSM_STATE == MSM_START) begin
                        state        <= IDLE;
                        prescaler    <= '0;
                        seconds_left <= SECONDS_INIT;
                        score        <= 4'd0;
                        time_up      <= 1'b0;
                        goal_met     <= 1'b0;
                        timed_active <= 1'b0;
                    end else if (state == RUNNING && bus.MSM_STATE == MSM_PLAY) begin
                        if (target_counted) begin
                            score <= score + 4'd1;
                        end
                        if (timed_active) begin
                            if (prescaler_wrap) begin
                                prescaler    <= '0;
                                tick         <= 1'b1;
                                seconds_left <= seconds_dec;
                            end else begin
                                prescaler <= prescaler + PRE_W'(1);
                            end
                            if (goal_hit) begin
                                state    <= WON;
                                goal_met <= 1'b1;
                            end else if (prescaler_wrap && seconds_left == 8'd1) begin
                                state   <= EXPIRED;
                                time_up <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.TICK_1HZ     = tick;
    assign bus.SECONDS_LEFT = seconds_left;
    assign bus.SCORE        = score;
    assign bus.TIME_UP      = time_up;
    assign bus.GOAL_MET     = goal_met;
    assign bus.TIMED_ACTIVE = timed_active;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed bench for game_timer_ctrl. Instance "dut"
// uses CLK_HZ=4, GAME_SECONDS=3, TARGET_GOAL=10 for round behaviour;
// instance "dut_enc" uses GAME_SECONDS=60 to check the SECONDS_LEFT
// encoding selected by GAME_TIMER_BCD_EN.
module tb_game_timer_ctrl;

    logic CLK;
    logic RESET;
    int   compared;
    int   mismatched;
    int   tick_count;

    game_timer_ctrl_if bus_a ();
    game_timer_ctrl_if bus_b ();

    game_timer_ctrl #(.CLK_HZ(4), .GAME_SECONDS(3), .TARGET_GOAL(10)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_a.slave)
    );

    game_timer_ctrl #(.CLK_HZ(4), .GAME_SECONDS(60), .TARGET_GOAL(10)) dut_enc (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_b.slave)
    );

    // 10 ns system clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected SECONDS_LEFT encoding for a plain seconds value
    function automatic logic [7:0] enc(input int v);
`ifdef GAME_TIMER_BCD_EN
        enc = 8'(((v / 10) << 4) | (v % 10));
`else
        enc = 8'(v);
`endif
    endfunction

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs of the main instance, then advance one edge and settle
    task automatic applyStimulus(input logic [1:0] msm, input logic timed, input logic target);
        bus_a.MSM_STATE      = msm;
        bus_a.TIMED_MODE     = timed;
        bus_a.TARGET_REACHED = target;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        RESET      = 1'b0;
        bus_b.MSM_STATE      = 2'b00;
        bus_b.TIMED_MODE     = 1'b1;
        bus_b.TARGET_REACHED = 1'b0;

        // Reset values while RESET is held low
        applyStimulus(2'b00, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("rst_tick", {7'd0, bus_a.TICK_1HZ}, 8'd0);
        checkOutput("rst_secs", bus_a.SECONDS_LEFT, enc(3));
        checkOutput("rst_score", {4'd0, bus_a.SCORE}, 8'd0);
        checkOutput("rst_timeup", {7'd0, bus_a.TIME_UP}, 8'd0);
        checkOutput("rst_goal", {7'd0, bus_a.GOAL_MET}, 8'd0);
        checkOutput("rst_active", {7'd0, bus_a.TIMED_ACTIVE}, 8'd0);
        RESET = 1'b1;
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("idle_active", {7'd0, bus_a.TIMED_ACTIVE}, 8'd1);

        // Timed expiry: ticks at 4, 8, 12 cycles after entry
        applyStimulus(2'b01, 1'b1, 1'b0);
        checkOutput("exp_entry_secs", bus_a.SECONDS_LEFT, enc(3));
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(2'b01, 1'b0, (k == 13));
            checkOutput($sformatf("exp_tick_%0d", k), {7'd0, bus_a.TICK_1HZ},
                        ((k % 4 == 0) && (k <= 12)) ? 8'd1 : 8'd0);
            checkOutput($sformatf("exp_secs_%0d", k), bus_a.SECONDS_LEFT,
                        enc((k <= 12) ? 3 - k / 4 : 0));
            checkOutput($sformatf("exp_timeup_%0d", k), {7'd0, bus_a.TIME_UP},
                        (k >= 12) ? 8'd1 : 8'd0);
        end
        checkOutput("exp_score_frozen", {4'd0, bus_a.SCORE}, 8'd0);
        checkOutput("exp_active_latched", {7'd0, bus_a.TIMED_ACTIVE}, 8'd1);
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("exp_exit_secs", bus_a.SECONDS_LEFT, enc(3));
        checkOutput("exp_exit_timeup", {7'd0, bus_a.TIME_UP}, 8'd0);

        // Goal met: ten targets sampled at edges 1..10, ticks at 4 and 8
        applyStimulus(2'b01, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(2'b01, 1'b1, 1'b1);
            checkOutput($sformatf("goal_score_%0d", k), {4'd0, bus_a.SCORE}, 8'(k));
        end
        checkOutput("goal_met", {7'd0, bus_a.GOAL_MET}, 8'd1);
        checkOutput("goal_secs", bus_a.SECONDS_LEFT, enc(1));
        applyStimulus(2'b01, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b01, 1'b1, 1'b0);
        end
        checkOutput("goal_score_sat", {4'd0, bus_a.SCORE}, 8'd10);
        checkOutput("goal_secs_frozen", bus_a.SECONDS_LEFT, enc(1));
        checkOutput("goal_no_timeup", {7'd0, bus_a.TIME_UP}, 8'd0);
        checkOutput("goal_held", {7'd0, bus_a.GOAL_MET}, 8'd1);
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("goal_exit", {7'd0, bus_a.GOAL_MET}, 8'd0);

        // Simultaneous tenth target and final tick at edge 12
        applyStimulus(2'b01, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(2'b01, 1'b1, (k >= 3));
        end
        checkOutput("sim_score", {4'd0, bus_a.SCORE}, 8'd10);
        checkOutput("sim_goal", {7'd0, bus_a.GOAL_MET}, 8'd1);
        checkOutput("sim_timeup", {7'd0, bus_a.TIME_UP}, 8'd0);
        checkOutput("sim_secs", bus_a.SECONDS_LEFT, enc(0));
        checkOutput("sim_tick", {7'd0, bus_a.TICK_1HZ}, 8'd1);
        applyStimulus(2'b01, 1'b1, 1'b0);
        checkOutput("sim_tick_off", {7'd0, bus_a.TICK_1HZ}, 8'd0);
        applyStimulus(2'b00, 1'b1, 1'b0);

        // Reset mid-round with SCORE = 3
        applyStimulus(2'b01, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b01, 1'b1, 1'b1);
        end
        checkOutput("mid_score_before", {4'd0, bus_a.SCORE}, 8'd3);
        RESET = 1'b0;
        applyStimulus(2'b01, 1'b1, 1'b0);
        RESET = 1'b1;
        checkOutput("mid_score", {4'd0, bus_a.SCORE}, 8'd0);
        checkOutput("mid_secs", bus_a.SECONDS_LEFT, enc(3));
        checkOutput("mid_active", {7'd0, bus_a.TIMED_ACTIVE}, 8'd0);
        checkOutput("mid_timeup", {7'd0, bus_a.TIME_UP}, 8'd0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Untimed round: 200 cycles = 50 ticks' worth, 5 targets, mode toggled
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("unt_idle_active", {7'd0, bus_a.TIMED_ACTIVE}, 8'd0);
        applyStimulus(2'b01, 1'b0, 1'b0);
        tick_count = 0;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(2'b01, (k >= 100), (k % 40 == 5));
            if (bus_a.TICK_1HZ) tick_count++;
        end
        checkOutput("unt_ticks", 8'(tick_count), 8'd0);
        checkOutput("unt_score", {4'd0, bus_a.SCORE}, 8'd5);
        checkOutput("unt_secs", bus_a.SECONDS_LEFT, enc(3));
        checkOutput("unt_active", {7'd0, bus_a.TIMED_ACTIVE}, 8'd0);
        applyStimulus(2'b00, 1'b0, 1'b0);

        // Encoding on the 60-second instance: 60 down to 49
        bus_b.MSM_STATE = 2'b01;
        @(posedge CLK);
        #1;
        checkOutput("enc_start", bus_b.SECONDS_LEFT, enc(60));
        for (int n = 1; n <= 11; n++) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge CLK);
                #1;
            end
            checkOutput($sformatf("enc_secs_%0d", n), bus_b.SECONDS_LEFT, enc(60 - n));
        end
        bus_b.MSM_STATE = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
